cic_output_scaler: RTL and testbench
====================================

CIC_OUTPUT_SCALER -- requirements
Module: cic_output_scaler

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 18, giving the input sample width (two's complement; matches the CIC interpolator register width for WIDTH=16, RMAX=4, N=2).
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16, giving the output sample width (two's complement); OUT_WIDTH <= IN_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port input_tdata, input, IN_WIDTH bits: signed sample from the CIC interpolator.
REQ-006 The block SHALL have port input_tvalid, input, 1 bit: input sample valid.
REQ-007 The block SHALL have port input_tready, output, 1 bit: block accepts input this cycle.
REQ-008 The block SHALL have port output_tdata, output, OUT_WIDTH bits: scaled, rounded, saturated sample.
REQ-009 The block SHALL have port output_tvalid, output, 1 bit: output sample valid.
REQ-010 The block SHALL have port output_tready, input, 1 bit: downstream accepts output.
REQ-011 The block SHALL have port shift, input, $clog2(IN_WIDTH+1) bits: right-shift amount (gain normalisation).
REQ-012 The block SHALL have port sat_clear, input, 1 bit: synchronous clear of the sticky saturation flag.
REQ-013 The block SHALL have port sat_flag, output, 1 bit: sticky flag set when any sample saturated.

Function
REQ-014 Transfers SHALL occur on a rising edge only when tvalid and tready are both high (AXI-Stream semantics); output_tvalid, once high, SHALL stay high with output_tdata stable until accepted.
REQ-015 shift SHALL be sampled together with input_tdata at each input transfer and carried with that sample; later shift changes SHALL NOT affect samples already accepted.
REQ-016 Effective shift s SHALL be min(shift, IN_WIDTH-1).
REQ-017 Stage 1 SHALL compute r = (x + (s>0 ? 2^(s-1) : 0)) >>> s in IN_WIDTH+1 signed bits (round half up, no internal overflow).
REQ-018 Stage 2 SHALL saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and register the result to output_tdata.
REQ-019 The datapath SHALL be a two-stage pipeline with per-stage valid bits; latency from input transfer to output_tvalid SHALL be exactly 2 cycles when not stalled.
REQ-020 A stage SHALL load when it is empty or its contents move forward in the same cycle; input_tready = NOT stage1_valid OR (stage2 empty OR output_tready).
REQ-021 With output_tready held high, throughput SHALL be one sample per cycle with no bubbles.
REQ-022 Under backpressure the block SHALL hold at most 2 samples, drop none, duplicate none, and preserve order.
REQ-023 sat_flag SHALL set on the cycle a saturated sample is loaded into stage 2 and hold until sat_clear; if set and clear coincide, set SHALL win.
REQ-024 No combinational path SHALL exist from input_tdata/shift to any output; input_tready MAY depend combinationally on output_tready.

Reset
REQ-025 While rst_n is low, both stage valids, output_tvalid, and sat_flag SHALL be 0 and output_tdata SHALL be 0, asynchronously.
REQ-026 input_tready SHALL read 1 one cycle after rst_n deasserts (pipeline empty).
REQ-027 Reset asserted mid-stream SHALL discard in-flight samples; no stale sample SHALL appear after release.

Verification
REQ-028 shift=2, inputs 7, -7, 6, -6 with output_tready=1 -> outputs 2, -2, 2, -1, each 2 cycles after its input, sat_flag=0.
REQ-029 shift=0, inputs 40000, -40000, 1000 -> outputs 32767, -32768, 1000; sat_flag=1 after first output, remains 1; sat_clear pulse -> 0.
REQ-030 shift=20 (clamped to 17), inputs 131071, -131072 -> outputs 1, -1.
REQ-031 Back-to-back inputs 1..6 (shift=0), output_tready low for 5 cycles then high -> input_tready drops after 2 accepted, outputs 1..6 in order, none lost.
REQ-032 Pulse rst_n low while 2 samples in flight -> output_tvalid=0 immediately, sat_flag=0, first post-reset output equals first post-reset input.
REQ-033 shift changed from 0 to 3 between two accepted inputs of 80 each -> outputs 80 then 10.

Source files
------------

// File: rtl/cic_output_scaler.sv
// Output scaler for the CIC interpolator: per-sample rounding right shift,
// saturation to OUT_WIDTH, and a two-stage AXI-Stream pipeline with sticky overflow.
module cic_output_scaler #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IN_WIDTH-1:0]              input_tdata,
    input  logic                             input_tvalid,
    output logic                             input_tready,
    output logic [OUT_WIDTH-1:0]             output_tdata,
    output logic                             output_tvalid,
    input  logic                             output_tready,
    input  logic [$clog2(IN_WIDTH+1)-1:0]    shift,
    input  logic                             sat_clear,
    output logic                             sat_flag
);

    localparam int SW = $clog2(IN_WIDTH + 1);
    localparam int RW = IN_WIDTH + 1;

    localparam logic [SW-1:0]        SMAX  = SW'(IN_WIDTH - 1);
    localparam logic [SW-1:0]        S_ONE = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] R_ONE = {{(RW-1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] OMAX  = RW'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [RW-1:0] OMIN  = ~OMAX;

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [RW-1:0] r);
        if (r > OMAX) begin
            saturate = OMAX[OUT_WIDTH-1:0];
        end else if (r < OMIN) begin
            saturate = OMIN[OUT_WIDTH-1:0];
        end else begin
            saturate = r[OUT_WIDTH-1:0];
        end
    endfunction

    function automatic logic is_saturated(input logic signed [RW-1:0] r);
        is_saturated = (r > OMAX) || (r < OMIN);
    endfunction

    logic [SW-1:0]        s_eff_s;
    logic signed [RW-1:0] x_ext_s;
    logic signed [RW-1:0] rnd_s;
    logic signed [RW-1:0] sum_s;
    logic signed [RW-1:0] r_s;
    logic                 s1_ready_s;
    logic                 s2_ready_s;
    logic                 sat_set_s;

    logic                 s1_valid_q, s1_valid_d;
    logic signed [RW-1:0] s1_r_q, s1_r_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                 sat_q, sat_d;

    // Round-half-up right shift of the incoming sample; one extra bit keeps the bias add exact.
    always_comb begin
        s_eff_s = (shift > SMAX) ? SMAX : shift;
        x_ext_s = {input_tdata[IN_WIDTH-1], input_tdata};
        if (s_eff_s != {SW{1'b0}}) begin
            rnd_s = R_ONE << (s_eff_s - S_ONE);
        end else begin
            rnd_s = {RW{1'b0}};
        end
        sum_s = x_ext_s + rnd_s;
        r_s   = sum_s >>> s_eff_s;
    end

    // Handshake and next-state for both stages; a stage loads when empty or draining.
    always_comb begin
        s2_ready_s = !s2_valid_q || output_tready;
        s1_ready_s = !s1_valid_q || s2_ready_s;

        if (s1_ready_s) begin
            s1_valid_d = input_tvalid;
            s1_r_d     = input_tvalid ? r_s : s1_r_q;
        end else begin
            s1_valid_d = s1_valid_q;
            s1_r_d     = s1_r_q;
        end

        if (s2_ready_s) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? saturate(s1_r_q) : s2_data_q;
        end else begin
            s2_valid_d = s2_valid_q;
            s2_data_d  = s2_data_q;
        end

        sat_set_s = s2_ready_s && s1_valid_q && is_saturated(s1_r_q);
        if (sat_set_s) begin
            sat_d = 1'b1;
        end else if (sat_clear) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    // Pipeline and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= {RW{1'b0}};
            s2_valid_q <= 1'b0;
            s2_data_q  <= {OUT_WIDTH{1'b0}};
            sat_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            sat_q      <= sat_d;
        end
    end

    assign input_tready  = s1_ready_s;
    assign output_tvalid = s2_valid_q;
    assign output_tdata  = s2_data_q;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_cic_output_scaler.sv
// Directed self-checking bench for cic_output_scaler (IN_WIDTH=18, OUT_WIDTH=16).
module tb_cic_output_scaler;

    logic        clk;
    logic        rst_n;
    logic [17:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  shift;
    logic        sat_clear;
    logic        sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    cic_output_scaler #(.IN_WIDTH(18), .OUT_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_tdata   (in_data),
        .input_tvalid  (in_valid),
        .input_tready  (in_ready),
        .output_tdata  (out_data),
        .output_tvalid (out_valid),
        .output_tready (out_ready),
        .shift         (shift),
        .sat_clear     (sat_clear),
        .sat_flag      (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
    endtask

    initial begin
        int acc;
        int rcv;

        rst_n = 1'b0; in_data = 18'd0; in_valid = 1'b0; out_ready = 1'b1;
        shift = 5'd0; sat_clear = 1'b0;
        step(); step();
        check("rst_ovalid", out_valid, 32'sd0);
        check("rst_odata", $signed(out_data), 32'sd0);
        check("rst_sat", sat_flag, 32'sd0);
        rst_n = 1'b1;
        step();
        check("rel_iready", in_ready, 32'sd1);

        // Rounding with shift=2, back-to-back, latency 2
        shift = 5'd2;
        push(18'sd7);
        check("lat_empty", out_valid, 32'sd0);
        push(-18'sd7);
        check("rnd_7_valid", out_valid, 32'sd1);
        check("rnd_7", $signed(out_data), 32'sd2);
        push(18'sd6);
        check("rnd_m7", $signed(out_data), -32'sd2);
        push(-18'sd6);
        check("rnd_6", $signed(out_data), 32'sd2);
        in_valid = 1'b0;
        step();
        check("rnd_m6", $signed(out_data), -32'sd1);
        check("rnd_valid_last", out_valid, 32'sd1);
        step();
        check("rnd_drained", out_valid, 32'sd0);
        check("rnd_sat", sat_flag, 32'sd0);

        // Saturation and sticky flag
        shift = 5'd0;
        push(18'sd40000);
        push(-18'sd40000);
        check("sat_pos", $signed(out_data), 32'sd32767);
        check("sat_set", sat_flag, 32'sd1);
        push(18'sd1000);
        check("sat_neg", $signed(out_data), -32'sd32768);
        in_valid = 1'b0;
        step();
        check("sat_pass", $signed(out_data), 32'sd1000);
        check("sat_sticky", sat_flag, 32'sd1);
        step();
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        check("sat_cleared", sat_flag, 32'sd0);
        push(18'sd40000);
        in_valid = 1'b0;
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;
        check("sat_set_wins", sat_flag, 32'sd1);
        check("sat_set_wins_data", $signed(out_data), 32'sd32767);
        step();
        sat_clear = 1'b1;
        step();
        sat_clear = 1'b0;

        // Shift clamp: 20 behaves as 17
        shift = 5'd20;
        push(18'sd131071);
        push(-18'sd131072);
        check("clamp_max", $signed(out_data), 32'sd1);
        in_valid = 1'b0;
        step();
        check("clamp_min", $signed(out_data), -32'sd1);
        check("clamp_nosat", sat_flag, 32'sd0);
        step();

        // Backpressure: 1..6 with output stalled 5 cycles
        shift = 5'd0;
        acc = 0;
        rcv = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 5);
            in_valid  = (acc < 6);
            in_data   = 18'(acc + 1);
            #1;
            if (c == 2) begin
                check("bp_iready_low", in_ready, 32'sd0);
                check("bp_accepted", acc, 32'sd2);
            end
            if (c == 4) begin
                check("bp_hold_valid", out_valid, 32'sd1);
                check("bp_hold_data", $signed(out_data), 32'sd1);
            end
            if (out_valid && out_ready) begin
                check("bp_order", $signed(out_data), rcv + 1);
                rcv++;
            end
            if (in_valid && in_ready) acc++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", rcv, 32'sd6);

        // Reset mid-stream with two samples in flight
        push(18'sd50000);
        push(18'sd6);
        in_valid = 1'b0;
        check("mid_sat_before", sat_flag, 32'sd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", out_valid, 32'sd0);
        check("mid_rst_sat", sat_flag, 32'sd0);
        check("mid_rst_odata", $signed(out_data), 32'sd0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_rel_iready", in_ready, 32'sd1);
        check("mid_no_stale", out_valid, 32'sd0);
        push(18'sd9);
        in_valid = 1'b0;
        step();
        check("mid_first_valid", out_valid, 32'sd1);
        check("mid_first_data", $signed(out_data), 32'sd9);
        step();

        // Shift is carried with each sample
        shift = 5'd0;
        push(18'sd80);
        shift = 5'd3;
        push(18'sd80);
        in_valid = 1'b0;
        check("shift_carry_0", $signed(out_data), 32'sd80);
        shift = 5'd0;
        step();
        check("shift_carry_3", $signed(out_data), 32'sd10);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
